// File: rtl/fifo_pkg.sv
// State encoding and default data width shared by the FIFO sender and receiver.
// Both sides decode the same 3-bit state values, so keep this the single source.
package fifo_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_FETCH = 3'd2,
    S_REQ   = 3'd3,
    S_GAP   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_tx_sender_ack_timer.sv
// Ack-wait cycle counter plus retry counter for the FIFO sender.
// expire flags the last waiting cycle; retries_exhausted flags the final allowed retry.
module ack_timer
  import fifo_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  input  logic retry_inc,
  output logic expire,
  output logic retries_exhausted
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY);

  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;

  // A retry restarts the wait window, so the gap cycle always begins with tcnt at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      rcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
      rcnt <= '0;
    end else if (retry_inc) begin
      tcnt <= '0;
      rcnt <= rcnt + 1'b1;
    end else if (tick) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign expire            = (tcnt == T_LAST);
  assign retries_exhausted = (rcnt == R_LAST);

endmodule

// File: rtl/fifo_tx_sender.sv
// Read-side sender: pops one FIFO word at a time and holds it on tx_data/tx_valid until acked.
// Missing acks trigger bounded re-presentation, then a sticky error until err_clr.
module fifo_tx_sender
  import fifo_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_rd_en,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          ack,
  input  logic          err_clr,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] xfer_count
);

  state_t state, state_nxt;
  logic   expire, exhausted;
  logic   tmr_clr, tmr_tick, tmr_retry, err_set;

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) u_ack_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .clr              (tmr_clr),
    .tick             (tmr_tick),
    .retry_inc        (tmr_retry),
    .expire           (expire),
    .retries_exhausted(exhausted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_tick  = 1'b0;
    tmr_retry = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_RD;
      S_RD:    state_nxt = S_FETCH;
      S_FETCH: begin
        tmr_clr   = 1'b1;
        state_nxt = S_REQ;
      end
      S_REQ: begin
        // Ack takes priority over an expiry landing in the same cycle.
        if (ack) begin
          state_nxt = S_IDLE;
        end else if (expire) begin
          if (exhausted) begin
            err_set   = 1'b1;
            state_nxt = S_ERR;
          end else begin
            tmr_retry = 1'b1;
            state_nxt = S_GAP;
          end
        end else begin
          tmr_tick = 1'b1;
        end
      end
      S_GAP:   state_nxt = S_REQ;
      S_ERR:   if (err_clr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fifo_rd_en = (state == S_RD);
  assign tx_valid   = (state == S_REQ);
  assign busy       = (state != S_IDLE);

  // FIFO data is valid in S_FETCH, one cycle after the pop strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= '0;
      err        <= 1'b0;
      xfer_count <= '0;
    end else begin
      if (state == S_FETCH) tx_data <= fifo_rd_data;
      if (err_set) err <= 1'b1;
      else if (state == S_ERR && err_clr) err <= 1'b0;
      if (state == S_REQ && ack) xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_tx_sender.sv
// Directed bench for fifo_tx_sender with a small array-backed FIFO read-port model.
module tb_fifo_tx_sender;

  localparam int DW = 8;
  localparam int AT = 4;
  localparam int MR = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          ack;
  logic          err_clr;
  logic          err;
  logic          busy;
  logic [CW-1:0] xfer_count;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int bad_pop = 0;

  always #5 clk = ~clk;

  fifo_tx_sender #(.DW(DW), .ACK_TIMEOUT(AT), .MAX_RETRY(MR), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .ack         (ack),
    .err_clr     (err_clr),
    .err         (err),
    .busy        (busy),
    .xfer_count  (xfer_count)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) bad_pop <= bad_pop + 1;
      fifo_rd_data <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      step(1);
      n++;
    end
    check("wait_valid", {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    logic [10:0] pat;
    rst_n   = 1'b0;
    ack     = 1'b0;
    err_clr = 1'b0;
    fifo_rd_data = '0;
    step(2);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_xfer", {28'd0, xfer_count}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single word: pop strobe, tx_valid 3 cycles after empty falls, one ack.
    push(8'hA5);
    step(1);
    check("t1_rd_en_hi", {31'd0, fifo_rd_en}, 32'd1);
    step(1);
    check("t1_rd_en_lo", {31'd0, fifo_rd_en}, 32'd0);
    check("t1_valid_lo", {31'd0, tx_valid}, 32'd0);
    step(1);
    check("t1_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_data", {24'd0, tx_data}, 32'hA5);
    step(1);
    ack_pulse();
    check("t1_xfer", {28'd0, xfer_count}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_hold", {24'd0, tx_data}, 32'hA5);
    check("t1_pops", rd_ptr, 32'd1);

    // Burst of four with immediate acks.
    for (int i = 1; i <= 4; i++) push(DW'(i));
    for (int i = 1; i <= 4; i++) begin
      wait_valid(10);
      check("t2_data", {24'd0, tx_data}, i);
      ack_pulse();
    end
    step(4);
    check("t2_xfer", {28'd0, xfer_count}, 32'd5);
    check("t2_pops", rd_ptr, 32'd5);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // Retry: valid drops one cycle at each 4-cycle expiry; same word re-presented.
    push(8'h3C);
    wait_valid(10);
    pat = 11'b101_1110_1111;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("t3_valid_pat", {31'd0, tx_valid}, {31'd0, pat[i]});
      check("t3_data", {24'd0, tx_data}, 32'h3C);
    end
    ack_pulse();
    check("t3_xfer", {28'd0, xfer_count}, 32'd6);
    check("t3_err", {31'd0, err}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // Exhaustion: 19 cycles in REQ/GAP, then sticky err and no pops.
    push(8'h77);
    push(8'h88);
    wait_valid(10);
    step(18);
    check("t4_err_early", {31'd0, err}, 32'd0);
    step(1);
    check("t4_err_set", {31'd0, err}, 32'd1);
    check("t4_valid", {31'd0, tx_valid}, 32'd0);
    step(5);
    check("t4_no_pop", rd_ptr, 32'd7);
    check("t4_err_hold", {31'd0, err}, 32'd1);
    check("t4_xfer", {28'd0, xfer_count}, 32'd6);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err_clr", {31'd0, err}, 32'd0);
    wait_valid(10);
    check("t4_next_word", {24'd0, tx_data}, 32'h88);
    ack_pulse();
    check("t4_xfer2", {28'd0, xfer_count}, 32'd7);

    // Ack coincident with expiry wins: straight to idle, not gap.
    push(8'h5A);
    wait_valid(10);
    step(3);
    ack_pulse();
    check("t5_race_xfer", {28'd0, xfer_count}, 32'd8);
    check("t5_race_busy", {31'd0, busy}, 32'd0);
    // Ack during the gap cycle is ignored.
    push(8'h6B);
    wait_valid(10);
    step(4);
    check("t5_gap", {31'd0, tx_valid}, 32'd0);
    ack_pulse();
    check("t5_gap_xfer", {28'd0, xfer_count}, 32'd8);
    check("t5_gap_rereq", {31'd0, tx_valid}, 32'd1);
    ack_pulse();
    check("t5_accept", {28'd0, xfer_count}, 32'd9);
    ack = 1'b1;
    err_clr = 1'b1;
    step(3);
    ack = 1'b0;
    err_clr = 1'b0;
    check("t5_idle_xfer", {28'd0, xfer_count}, 32'd9);
    check("t5_idle_err", {31'd0, err}, 32'd0);
    check("t5_pops", rd_ptr, 32'd10);

    // Async reset mid-cycle while in REQ.
    push(8'hC3);
    wait_valid(10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, tx_valid}, 32'd0);
    check("t6_data", {24'd0, tx_data}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_xfer", {28'd0, xfer_count}, 32'd0);
    step(1);
    rst_n = 1'b1;
    push(8'hD4);
    wait_valid(10);
    check("t6_next", {24'd0, tx_data}, 32'hD4);
    ack_pulse();
    check("t6_xfer2", {28'd0, xfer_count}, 32'd1);

    // Counter wrap at 2^CW.
    for (int i = 0; i < 15; i++) begin
      push(DW'(8'h40 + i));
      wait_valid(10);
      check("t7_data", {24'd0, tx_data}, 32'h40 + i);
      ack_pulse();
      if (i == 13) check("t7_xfer15", {28'd0, xfer_count}, 32'd15);
    end
    check("t7_wrap", {28'd0, xfer_count}, 32'd0);
    check("bad_pops", bad_pop, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
